ballot_frame_decoder: RTL and testbench
=======================================

// Module: ballot_frame_decoder
// PURPOSE
//  Upstream front end of the VoterPlus tally stage. Takes a byte stream over a
//  valid/ready handshake, parses 3-byte ballot frames and checks each one. For
//  each good frame it emits a one-cycle one-hot pulse on np/vip/vvip, which the
//  downstream voter ORs into its sticky voter masks. Counts good and bad frames.
// PARAMETERS
//  SYNC     8'hA5  frame start byte
//  TIMEOUT  16     max consecutive cycles without an accepted byte inside a frame
// PORTS
//  clk        in   1   system clock, all state on posedge
//  reset      in   1   synchronous, active-high
//  in_valid   in   1   in_data holds a byte
//  in_data    in   8   stream byte
//  in_ready   out  1   decoder can accept a byte; byte taken when in_valid&&in_ready
//  np         out  32  one-hot normal-voter pulse (id 0..31)
//  vip        out  8   one-hot VIP pulse (id 0..7)
//  vvip       out  1   VVIP pulse
//  ok_cnt     out  8   good frames, saturates at 255
//  err_cnt    out  8   rejected frames, saturates at 255
// BEHAVIOUR
//  Frame: SYNC, HDR={cls[7:6],id[5:0]}, CHK=~HDR. cls 00=normal, 01=vip, 10=vvip, 11=illegal.
//  Reset: state IDLE, np=0, vip=0, vvip=0, ok_cnt=0, err_cnt=0, timeout counter=0.
//   reset overrides every other event; a frame in flight is dropped with no count change.
//  FSM states: IDLE, HDR, CHK, EMIT. in_ready = (state != EMIT), combinational.
//  IDLE: accepted byte == SYNC -> HDR. Any other byte is dropped silently (no error).
//  HDR: accepted byte is latched as header -> CHK. A SYNC value here is plain header data.
//  CHK: on an accepted byte, the frame is bad if any of these hold:
//   byte != ~hdr; cls==11; cls==00 and id>31; cls==01 and id>7; cls==10 and id!=0.
//   bad -> IDLE, err_cnt+1 on the same edge.
//   good -> EMIT; np/vip/vvip registered on that edge.
//  EMIT: lasts exactly 1 cycle. The selected pulse bit is high and in_ready=0.
//   ok_cnt+1 on the edge that leaves EMIT. Next state IDLE; pulses return to 0.
//  Latency: pulse is visible the cycle after the CHK byte is accepted. Exactly one
//   bit across np|vip|vvip is high, and only during EMIT. All pulse outputs are 0 otherwise.
//  Timeout: in HDR/CHK, a counter increments each cycle with no accepted byte and
//   clears on every accepted byte. On the cycle it reaches TIMEOUT: -> IDLE, err_cnt+1,
//   counter cleared. The counter is held at 0 in IDLE/EMIT. Width $clog2(TIMEOUT+1).
//  Throughput: at most one frame per 4 cycles (3 bytes + EMIT).
//  Saturation: a counter at 255 stays at 255; no wrap.
//  in_valid while in_ready=0: byte is not consumed; upstream must hold it.
// TESTING
//  1 normal: A5,05,FA back-to-back -> np=32'h0000_0020 for 1 cycle, 4th cycle after
//    the first byte; ok_cnt=1; in_ready=0 that cycle.
//  2 vip/vvip: A5,43,BC -> vip=8'h08; then A5,80,7F -> vvip=1; ok_cnt=2, err_cnt=0.
//  3 rejects: A5,05,00 (bad chk), A5,C0,3F (cls 11), A5,28,D7 (id 40) -> no pulses, err_cnt=3.
//  4 sync hunt + timeout: 00,FF,A5, then 16 idle cycles -> err_cnt=1, IDLE;
//    next A5,1F,E0 -> np[31]=1.
//  5 reset mid-frame: A5,05, reset 1 cycle, FA -> no pulse; counters 0.
//  6 saturation/stall: 256 good frames with in_valid held through EMIT -> ok_cnt=255,
//    no byte lost; the pulse count at the bench monitor = 256.

Source files
------------

// File: rtl/ballot_frame_decoder.sv
// Parses 3-byte ballot frames (SYNC, HDR, ~HDR) from a valid/ready byte stream,
// pulses the selected voter line for one cycle per good frame and counts outcomes.
module ballot_frame_decoder #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] np,
  output logic [7:0]  vip,
  output logic        vvip,
  output logic [7:0]  ok_cnt,
  output logic [7:0]  err_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_CHK,
    S_EMIT
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    hdr_q, hdr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   np_q, np_d;
  logic [7:0]    vip_q, vip_d;
  logic          vvip_q, vvip_d;
  logic [7:0]    ok_q, ok_d;
  logic [7:0]    err_q, err_d;

  logic          accept;
  logic          waiting;
  logic          id_ok;
  logic          frame_good;
  logic [1:0]    cls;
  logic [5:0]    id;
  logic [TW-1:0] tmo_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_ready = (state_q != S_EMIT);
  assign accept   = in_valid && in_ready;
  assign waiting  = ((state_q == S_HDR) || (state_q == S_CHK)) && !accept;
  assign cls      = hdr_q[7:6];
  assign id       = hdr_q[5:0];
  assign tmo_inc  = tmo_q + 1'b1;

  // Class-dependent id range; class 11 is never legal.
  always_comb begin
    id_ok = 1'b0;
    case (cls)
      2'b00:   id_ok = ~id[5];
      2'b01:   id_ok = (id[5:3] == 3'd0);
      2'b10:   id_ok = (id == 6'd0);
      default: id_ok = 1'b0;
    endcase
  end

  assign frame_good = (in_data == ~hdr_q) && id_ok;

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    tmo_d   = '0;
    np_d    = '0;
    vip_d   = '0;
    vvip_d  = 1'b0;
    ok_d    = ok_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept && (in_data == SYNC)) begin
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (accept) begin
          hdr_d   = in_data;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (frame_good) begin
            state_d = S_EMIT;
            case (cls)
              2'b00:   np_d   = 32'h1 << id[4:0];
              2'b01:   vip_d  = 8'h1 << id[2:0];
              default: vvip_d = 1'b1;
            endcase
          end else begin
            state_d = S_IDLE;
            err_d   = sat_inc(err_q);
          end
        end
      end
      S_EMIT: begin
        state_d = S_IDLE;
        ok_d    = sat_inc(ok_q);
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled frame is abandoned on the cycle the idle count reaches the limit.
    if (waiting) begin
      if (tmo_inc == TMO_LIMIT) begin
        state_d = S_IDLE;
        err_d   = sat_inc(err_q);
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      tmo_q   <= '0;
      np_q    <= '0;
      vip_q   <= '0;
      vvip_q  <= 1'b0;
      ok_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      tmo_q   <= tmo_d;
      np_q    <= np_d;
      vip_q   <= vip_d;
      vvip_q  <= vvip_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign np      = np_q;
  assign vip     = vip_q;
  assign vvip    = vvip_q;
  assign ok_cnt  = ok_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_ballot_frame_decoder.sv
// Bench for ballot_frame_decoder: directed scenarios plus random frame traffic,
// every cycle compared with a queue-based frame model.
module tb_ballot_frame_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] np;
  logic [7:0]  vip;
  logic        vvip;
  logic [7:0]  ok_cnt;
  logic [7:0]  err_cnt;

  ballot_frame_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .np       (np),
    .vip      (vip),
    .vvip     (vvip),
    .ok_cnt   (ok_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int pulses_seen = 0;

  // Reference model: bytes collected for the current frame plus expected outputs.
  logic [7:0]  m_frame[$];
  int          m_idle;
  bit          m_emit;
  logic [31:0] m_np;
  logic [7:0]  m_vip;
  logic        m_vvip;
  int          m_ok;
  int          m_err;
  int          m_good_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic void m_reset();
    m_frame.delete();
    m_idle = 0;
    m_emit = 0;
    m_np   = '0;
    m_vip  = '0;
    m_vvip = 1'b0;
    m_ok   = 0;
    m_err  = 0;
  endfunction

  function automatic void m_judge(input logic [7:0] hdr, input logic [7:0] chk);
    int cls = int'(hdr) / 64;
    int id  = int'(hdr) % 64;
    bit good = (int'(chk) == 255 - int'(hdr)) &&
               ((cls == 0 && id < 32) || (cls == 1 && id < 8) || (cls == 2 && id == 0));
    if (good) begin
      m_emit = 1;
      m_good_total++;
      if (cls == 0) m_np = 32'd1 << id;
      else if (cls == 1) m_vip = 8'd1 << id;
      else m_vvip = 1'b1;
    end else begin
      m_err = sat(m_err);
    end
  endfunction

  function automatic void m_clock(input logic v, input logic [7:0] d, input logic r);
    if (r) begin
      m_reset();
    end else if (m_emit) begin
      m_emit = 0;
      m_np   = '0;
      m_vip  = '0;
      m_vvip = 1'b0;
      m_ok   = sat(m_ok);
    end else if (v) begin
      m_idle = 0;
      if (m_frame.size() == 0) begin
        if (d == 8'hA5) m_frame.push_back(d);
      end else if (m_frame.size() == 1) begin
        m_frame.push_back(d);
      end else begin
        m_judge(m_frame[1], d);
        m_frame.delete();
      end
    end else if (m_frame.size() != 0) begin
      m_idle++;
      if (m_idle == 16) begin
        m_err = sat(m_err);
        m_frame.delete();
        m_idle = 0;
      end
    end
  endfunction

  task automatic compare_all();
    check("in_ready", 32'(in_ready), 32'(!m_emit));
    check("np", np, m_np);
    check("vip", 32'(vip), 32'(m_vip));
    check("vvip", 32'(vvip), 32'(m_vvip));
    check("ok_cnt", 32'(ok_cnt), 32'(m_ok));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    pulses_seen += $countones({np, vip, vvip});
  endtask

  // One clock: drive inputs, update the model across the edge, compare at negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic r, output logic took);
    in_valid = v;
    in_data  = d;
    reset    = r;
    @(posedge clk);
    took = v && !r && !m_emit;
    m_clock(v, d, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    logic took;
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, took);
  endtask

  task automatic do_reset();
    logic took;
    step(1'b0, 8'h00, 1'b1, took);
  endtask

  task automatic send_byte(input logic [7:0] d);
    logic took;
    int   n;
    took = 1'b0;
    n = 0;
    while (!took && n < 50) begin
      step(1'b1, d, 1'b0, took);
      n++;
    end
    check("send_accept", 32'(took), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] chk, input bit gaps);
    logic [7:0] b[3];
    b[0] = 8'hA5;
    b[1] = hdr;
    b[2] = chk;
    for (int i = 0; i < 3; i++) begin
      if (gaps) begin
        if ($urandom_range(0, 19) == 0) idle($urandom_range(10, 20));
        else idle($urandom_range(0, 3));
      end
      send_byte(b[i]);
    end
    $display("frame A5 %h %h -> ok=%0d err=%0d", hdr, chk, ok_cnt, err_cnt);
  endtask

  initial begin
    int p0;
    int kind;
    logic [7:0] hdr;
    logic [7:0] chk;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b1;
    do_reset();
    do_reset();
    check("reset_ok", 32'(ok_cnt), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);

    // Normal voter 5
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'hFA);
    check("t1_np", np, 32'h0000_0020);
    check("t1_ready", 32'(in_ready), 32'd0);
    idle(1);
    check("t1_ok", 32'(ok_cnt), 32'd1);
    check("t1_np_clear", np, 32'd0);
    $display("test1 normal frame done");

    do_reset();
    send_frame(8'h43, 8'hBC, 0);
    check("t2_vip", 32'(vip), 32'h08);
    send_frame(8'h80, 8'h7F, 0);
    check("t2_vvip", 32'(vvip), 32'd1);
    idle(1);
    check("t2_ok", 32'(ok_cnt), 32'd2);
    check("t2_err", 32'(err_cnt), 32'd0);

    do_reset();
    p0 = pulses_seen;
    send_frame(8'h05, 8'h00, 0);
    send_frame(8'hC0, 8'h3F, 0);
    send_frame(8'h28, 8'hD7, 0);
    idle(1);
    check("t3_err", 32'(err_cnt), 32'd3);
    check("t3_pulses", 32'(pulses_seen - p0), 32'd0);

    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    idle(15);
    check("t4_err_before", 32'(err_cnt), 32'd0);
    idle(1);
    check("t4_err_timeout", 32'(err_cnt), 32'd1);
    send_frame(8'h1F, 8'hE0, 0);
    check("t4_np31", np, 32'h8000_0000);
    idle(1);

    do_reset();
    p0 = pulses_seen;
    send_byte(8'hA5);
    send_byte(8'h05);
    do_reset();
    send_byte(8'hFA);
    idle(2);
    check("t5_ok", 32'(ok_cnt), 32'd0);
    check("t5_err", 32'(err_cnt), 32'd0);
    check("t5_pulses", 32'(pulses_seen - p0), 32'd0);

    do_reset();
    p0 = pulses_seen;
    for (int i = 0; i < 256; i++) begin
      hdr = {3'b000, 5'($urandom_range(0, 31))};
      send_frame(hdr, ~hdr, 0);
    end
    idle(2);
    check("t6_ok_sat", 32'(ok_cnt), 32'd255);
    check("t6_pulses", 32'(pulses_seen - p0), 32'd256);

    do_reset();
    p0 = pulses_seen;
    m_good_total = 0;
    for (int f = 0; f < 300; f++) begin
      kind = $urandom_range(0, 9);
      hdr = 8'($urandom);
      chk = ~hdr;
      case (kind)
        0: hdr = {3'b000, 5'($urandom_range(0, 31))};
        1: hdr = {5'b01000, 3'($urandom_range(0, 7))};
        2: hdr = 8'h80;
        3: chk = 8'($urandom);
        4: hdr = {2'b11, 6'($urandom)};
        5: hdr = {3'b001, 5'($urandom)};
        default: ;
      endcase
      if (kind != 2 && kind != 3 && kind < 6) chk = ~hdr;
      if (kind == 6) begin
        send_byte(8'($urandom));
      end else if (kind == 7) begin
        send_byte(8'hA5);
        idle($urandom_range(14, 20));
      end else if (kind == 8 && $urandom_range(0, 9) == 0) begin
        send_byte(8'hA5);
        do_reset();
      end else begin
        send_frame(hdr, chk, 1);
      end
    end
    idle(20);
    check("rand_pulses", 32'(pulses_seen - p0), 32'(m_good_total));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
